// File: rtl/bus_arbiter_if.sv
// Bus arbitration handshake bundle: per-source requests in, one-hot grant,
// mux select and status pulses out. master = arbiter side, slave = requester side.
interface bus_arbiter_if #(
  parameter int N = 3
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req_in;
  logic [N-1:0]  grant_out;
  logic [SW-1:0] sel_out;
  logic          bus_valid_out;
  logic          owner_changed_out;

  modport master (
    input  req_in,
    output grant_out,
    output sel_out,
    output bus_valid_out,
    output owner_changed_out
  );

  modport slave (
    output req_in,
    input  grant_out,
    input  sel_out,
    input  bus_valid_out,
    input  owner_changed_out
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the MyCPU internal data bus with registered grants.
// Optional hold-limit preemption is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bus_arbiter_if.master  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("bus_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  grant_reg;
  logic [SW-1:0] sel_reg;
  logic [SW-1:0] last_reg;
  logic          valid_reg;
  logic          changed_reg;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt_reg;
  logic          others_pending;
  assign others_pending = |(bus.req_in & ~grant_reg);
`endif

  logic [SW-1:0] win;
  logic [SW-1:0] hi_win;
  logic [SW-1:0] lo_win;
  logic          hi_found;
  logic [N-1:0]  win_onehot;
  logic          owner_req;

  // Lowest requesting index above last wins; otherwise wrap to the lowest at or below last.
  always_comb begin
    hi_win   = '0;
    lo_win   = '0;
    hi_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (bus.req_in[j]) begin
        if (SW'(j) > last_reg) begin
          hi_found = 1'b1;
          hi_win   = SW'(j);
        end else begin
          lo_win = SW'(j);
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign win_onehot[gi] = (win == SW'(gi));
    end
  endgenerate

  assign owner_req = |(bus.req_in & grant_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      sel_reg      <= '0;
      last_reg     <= SW'(N - 1);
      valid_reg    <= 1'b0;
      changed_reg  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      changed_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|bus.req_in) begin
            grant_reg    <= win_onehot;
            sel_reg      <= win;
            last_reg     <= win;
            valid_reg    <= 1'b1;
            changed_reg  <= 1'b1;
            state_reg    <= GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
            // The first grant cycle already counts toward the hold limit.
            hold_cnt_reg <= CW'(1);
`endif
          end
        end
        GRANT: begin
`ifdef BUS_ARB_TIMEOUT_EN
          if (!owner_req || (hold_cnt_reg == CW'(MAX_HOLD) && others_pending)) begin
            grant_reg    <= '0;
            valid_reg    <= 1'b0;
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg < CW'(MAX_HOLD)) begin
            hold_cnt_reg <= hold_cnt_reg + CW'(1);
          end
`else
          if (!owner_req) begin
            grant_reg <= '0;
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
`endif
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_out         = grant_reg;
  assign bus.sel_out           = sel_reg;
  assign bus.bus_valid_out     = valid_reg;
  assign bus.owner_changed_out = changed_reg;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed vector bench for bus_arbiter (N=3): reset, round-robin order, burst hold,
// wrap-around, asynchronous reset mid-grant and, when compiled in, hold-limit preemption.
module tb_bus_arbiter;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 8;
`endif

  logic clk;
  logic rst_n;
  int   n_compared;
  int   n_mismatched;

  bus_arbiter_if #(.N(3)) bus ();

  bus_arbiter #(.N(3), .MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] g;
    logic [1:0] s;
    logic       v;
    logic       c;
    string      name;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [2:0] req, input logic [2:0] g, input logic [1:0] s,
                              input logic v, input logic c, input string name);
    vec_t e;
    e.req = req; e.g = g; e.s = s; e.v = v; e.c = c; e.name = name;
    vq.push_back(e);
  endfunction

  task automatic check(input string name, input logic [2:0] g, input logic [1:0] s,
                       input logic v, input logic c);
    n_compared++;
    if ({bus.grant_out, bus.sel_out, bus.bus_valid_out, bus.owner_changed_out} !== {g, s, v, c}) begin
      n_mismatched++;
      $display("FAIL %s: got grant=%b sel=%0d valid=%b chg=%b, want grant=%b sel=%0d valid=%b chg=%b",
               name, bus.grant_out, bus.sel_out, bus.bus_valid_out, bus.owner_changed_out, g, s, v, c);
    end else begin
      $display("ok   %s: req=%b grant=%b sel=%0d valid=%b chg=%b",
               name, bus.req_in, bus.grant_out, bus.sel_out, bus.bus_valid_out, bus.owner_changed_out);
    end
  endtask

  task automatic step(input logic [2:0] r);
    bus.req_in = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run_queue();
    vec_t e;
    while (vq.size() > 0) begin
      e = vq.pop_front();
      step(e.req);
      check(e.name, e.g, e.s, e.v, e.c);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst_n        = 1'b0;
    bus.req_in   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 3'b000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin order 0,1,2,0 with one idle cycle between owners.
    add(3'b111, 3'b001, 2'd0, 1, 1, "rr_g0");
    add(3'b110, 3'b000, 2'd0, 0, 0, "rr_idle0");
    add(3'b111, 3'b010, 2'd1, 1, 1, "rr_g1");
    add(3'b101, 3'b000, 2'd1, 0, 0, "rr_idle1");
    add(3'b111, 3'b100, 2'd2, 1, 1, "rr_g2");
    add(3'b011, 3'b000, 2'd2, 0, 0, "rr_idle2");
    add(3'b111, 3'b001, 2'd0, 1, 1, "rr_g0_again");
    add(3'b111, 3'b001, 2'd0, 1, 0, "hold_ignores_others");
    add(3'b110, 3'b000, 2'd0, 0, 0, "release0");
    add(3'b001, 3'b001, 2'd0, 1, 1, "rerequest_alone");
    add(3'b000, 3'b000, 2'd0, 0, 0, "release_all");
    add(3'b000, 3'b000, 2'd0, 0, 0, "idle_stays");
    add(3'b011, 3'b010, 2'd1, 1, 1, "burst_g1");
`ifndef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 9; i++) add(3'b011, 3'b010, 2'd1, 1, 0, "burst_hold");
`endif
    add(3'b001, 3'b000, 2'd1, 0, 0, "burst_idle_sel");
    add(3'b001, 3'b001, 2'd0, 1, 1, "after_burst_g0");
    add(3'b100, 3'b000, 2'd0, 0, 0, "release0_b");
    add(3'b100, 3'b100, 2'd2, 1, 1, "g2_last2");
    add(3'b000, 3'b000, 2'd2, 0, 0, "release2");
    add(3'b101, 3'b001, 2'd0, 1, 1, "wrap_g0_first");
    add(3'b100, 3'b000, 2'd0, 0, 0, "wrap_release0");
    add(3'b100, 3'b100, 2'd2, 1, 1, "wrap_g2_next");
    add(3'b000, 3'b000, 2'd2, 0, 0, "wrap_release2");
    add(3'b010, 3'b010, 2'd1, 1, 1, "pre_rst_g1");
    run_queue();

    // Reset mid-cycle: outputs clear without a clock edge and last returns to N-1.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_immediate", 3'b000, 2'd0, 1'b0, 1'b0);
    bus.req_in = 3'b110;
    @(negedge clk);
    check("async_rst_hold", 3'b000, 2'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("async_rst_edge", 3'b000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_g1", 3'b010, 2'd1, 1'b1, 1'b1);
    add(3'b110, 3'b010, 2'd1, 1, 0, "post_rst_pulse_once");
    add(3'b000, 3'b000, 2'd1, 0, 0, "post_rst_release");

`ifdef BUS_ARB_TIMEOUT_EN
    // Owner 0 preempted after MAX_HOLD grant cycles while requester 2 waits.
    add(3'b001, 3'b001, 2'd0, 1, 1, "to_g0");
    for (int i = 0; i < 3; i++) add(3'b101, 3'b001, 2'd0, 1, 0, "to_hold");
    add(3'b101, 3'b000, 2'd0, 0, 0, "to_preempt");
    add(3'b101, 3'b100, 2'd2, 1, 1, "to_g2");
    add(3'b001, 3'b000, 2'd2, 0, 0, "to_release2");
    add(3'b001, 3'b001, 2'd0, 1, 1, "solo_g0");
    for (int i = 0; i < 25; i++) add(3'b001, 3'b001, 2'd0, 1, 0, "solo_persist");
    add(3'b000, 3'b000, 2'd0, 0, 0, "solo_release");
`endif
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
